bms_adc_sampler: RTL and testbench
==================================

// Module: bms_adc_sampler
// PURPOSE
//  Producer side of the SoC estimator's voltage/current sample interface. Drives an external 2-channel
//  serial ADC (SPI, 16-bit frames) once per sample period, converts raw codes to the estimator's format
//  (unsigned pack voltage, signed offset-removed current), and presents both words with a 1-cycle valid.
// PARAMETERS
//  CLK_DIV     50_000  sample period in clk cycles (1 ms @ 50 MHz); must be >= 70*SCLK_HALF+2
//  SCLK_HALF   25      clk cycles per SCLK half-period (1 MHz SCLK @ 50 MHz)
//  V_CH        3'd0    ADC channel address of pack voltage
//  I_CH        3'd1    ADC channel address of current-sense amp
//  CUR_OFFSET  32768   ADC code for 0 A (bipolar mid-scale)
// PORTS
//  clk           in   1   system clock, 50 MHz
//  rst_n         in   1   synchronous active-low reset
//  enable        in   1   1 = sample-period timer runs
//  overrun_clr   in   1   1-cycle pulse clears overrun
//  adc_sclk      out  1   SPI clock, idles high
//  adc_cs_n      out  1   ADC chip select, active low
//  adc_mosi      out  1   command bit, changes on SCLK falling edge
//  adc_miso      in   1   result bit, sampled on SCLK rising edge
//  voltage       out  16  latest voltage code (unsigned, 65535 = 700 V)
//  current       out  16  latest current, signed, 0.1 A units, = raw - CUR_OFFSET
//  sample_valid  out  1   1-cycle pulse: voltage/current just updated (same cycle)
//  busy          out  1   acquisition sequence in progress
//  overrun       out  1   sticky: period tick arrived while busy
// BEHAVIOUR
//  Reset (rst_n low at posedge): voltage=0, current=0, sample_valid=0, busy=0, overrun=0, adc_cs_n=1,
//   adc_sclk=1, adc_mosi=0, timer=0, FSM=IDLE. Reset mid-frame aborts it; no partial update.
//  Timer: counts 0..CLK_DIV-1 while enable=1; tick = (cnt==CLK_DIV-1), wraps to 0. enable=0 holds cnt at 0;
//   a sequence already running completes.
//  FSM: IDLE -> CS_SETUP -> SHIFT -> CS_HOLD -> GAP -> CS_SETUP -> SHIFT -> CS_HOLD -> UPDATE -> IDLE.
//   IDLE: on tick start frame 0 (channel V_CH), busy=1.  CS_SETUP: cs_n low, sclk high, 1 half-period.
//   SHIFT: 16 SCLK periods (32 halves); mosi = cmd {2'b00,ch[2:0],11'b0} MSB first, bit k driven on falling
//   edge k; miso bit sampled on each rising edge into 16-bit shift reg, MSB first. ADC returns the
//   channel addressed in the same frame.  CS_HOLD: sclk high, 1 half-period, then cs_n high.
//   GAP: cs_n high 2 half-periods, then frame 1 (I_CH).  UPDATE: one cycle; sample_valid=1, busy=0.
//  Latency: tick cycle T -> sample_valid at T+70*SCLK_HALF+1 (1751 at defaults).
//  Arithmetic: current = $signed({1'b0,raw_i}) - CUR_OFFSET, 17-bit then truncate (range -32768..32767,
//   no saturation needed). voltage = raw_v. Both outputs hold between updates.
//  Tick while busy: tick ignored, overrun<=1. overrun_clr and new overrun same cycle: set wins.
// CONFIGURATION
//  ADC_AVG_EN defined: per-channel 18-bit accumulators (signed for current) sum 4 consecutive sequences;
//   outputs/sample_valid update only on every 4th UPDATE with sum>>>2 (arith shift for current);
//   accumulators and phase counter cleared by reset. Undefined: outputs update every sequence, no accumulators.
// STRUCTURE
//  bms_pkg: FSM state enum, SPI command-word builder constant/function, ADC_CH_W=3, ADC_BITS=16.
//  Sub-module bms_spi_frame: one 16-bit CPOL=1 frame (start/done handshake, cmd in, data out,
//   SCLK_HALF param); top holds timer, sequencing FSM, conversion, averaging, overrun.
// TESTING
//  ADC model returns 16'hA5C3 on V_CH, 16'h8064 on I_CH -> voltage=16'hA5C3, current=+100 at cycle T+1751.
//  I_CH code 16'h7F9C -> current=-100; code 16'h0000 -> -32768; 16'hFFFF -> +32767.
//  Check mosi: frame0 cmd 16'h0000, frame1 16'h0800; 16 SCLK falls per frame; cs_n high gap = 50 cycles.
//  CLK_DIV=1000, SCLK_HALF=25: tick during busy -> overrun=1, no extra frames; overrun_clr -> 0.
//  rst_n low mid-SHIFT -> next cycle cs_n=1, sclk=1, outputs 0, no sample_valid; resumes after next tick.
//  ADC_AVG_EN: I codes 32868,32868,32868,32772 -> single sample_valid after 4th sequence, current=+76.

Source files
------------

// File: rtl/bms_pkg.sv
// bms_pkg: shared FSM state types, ADC widths and the SPI command-word builder
package bms_pkg;
  localparam int ADC_CH_W = 3;
  localparam int ADC_BITS = 16;
  typedef enum logic [1:0] {S_IDLE, S_FRAME, S_GAP, S_UPDATE} seq_t;
  typedef enum logic [1:0] {F_IDLE, F_CS_SETUP, F_SHIFT, F_CS_HOLD} frame_t;
  function automatic logic [ADC_BITS-1:0] adc_cmd(input logic [ADC_CH_W-1:0] ch);
    return {2'b00, ch, 11'b0};
  endfunction
endpackage

// File: rtl/bms_spi_frame.sv
// bms_spi_frame: one 16-bit CPOL=1 SPI frame (CS setup, 16 SCLK periods, CS hold)
//  clk, rst_n      clock, synchronous active-low reset
//  start, cmd      1-cycle start pulse with the command word to send MSB first
//  done, data      1-cycle pulse at the end of CS hold; data holds the received word
//  sclk, cs_n      SPI clock (idles high) and chip select
//  mosi, miso      command out (changes on SCLK fall), result in (sampled on SCLK rise)
module bms_spi_frame import bms_pkg::*; #(
  parameter int SCLK_HALF = 25
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [ADC_BITS-1:0] cmd,
  output logic                done,
  output logic [ADC_BITS-1:0] data,
  output logic                sclk,
  output logic                cs_n,
  output logic                mosi,
  input  logic                miso
);
  localparam int HW = $clog2(SCLK_HALF + 1);
  frame_t st, st_n;
  logic [HW-1:0] hcnt;
  logic [4:0] half;
  logic [ADC_BITS-1:0] cmd_q;
  logic half_end;
  assign half_end = hcnt == HW'(SCLK_HALF - 1);
  always_ff @(posedge clk) begin
    if (!rst_n) st <= F_IDLE;
    else st <= st_n;
  end
  always_comb begin
    st_n = st;
    done = 1'b0;
    case (st)
      F_IDLE:     if (start) st_n = F_CS_SETUP;
      F_CS_SETUP: if (half_end) st_n = F_SHIFT;
      F_SHIFT:    if (half_end && half == 5'd31) st_n = F_CS_HOLD;
      default: begin
        st_n = half_end ? F_IDLE : F_CS_HOLD;
        done = half_end;
      end
    endcase
  end
  // even halves are SCLK-low; the shift at the end of an even half coincides with the rising edge
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hcnt <= '0;
      half <= '0;
      cmd_q <= '0;
      data <= '0;
    end else begin
      hcnt <= (st == F_IDLE || half_end) ? '0 : hcnt + 1'b1;
      half <= st != F_SHIFT ? '0 : half_end ? half + 1'b1 : half;
      if (st == F_IDLE && start) cmd_q <= cmd;
      if (st == F_SHIFT && half_end && !half[0]) data <= {data[ADC_BITS-2:0], miso};
    end
  end
  assign cs_n = st == F_IDLE;
  assign sclk = !(st == F_SHIFT && !half[0]);
  assign mosi = st == F_SHIFT && cmd_q[4'd15 - half[4:1]];
endmodule

// File: rtl/bms_adc_sampler.sv
// bms_adc_sampler: periodic two-channel SPI ADC acquisition producing voltage/current samples
//  clk, rst_n              clock, synchronous active-low reset
//  enable, overrun_clr     sample timer run, sticky overrun clear pulse
//  adc_sclk/cs_n/mosi/miso SPI link to the external ADC
//  voltage, current        latest unsigned voltage code, signed offset-removed current
//  sample_valid, busy      1-cycle update strobe, acquisition in progress
//  overrun                 sticky: period tick arrived while busy
//  ADC_AVG_EN              when defined, outputs carry the mean of 4 consecutive sequences
module bms_adc_sampler import bms_pkg::*; #(
  parameter int                  CLK_DIV    = 50_000,
  parameter int                  SCLK_HALF  = 25,
  parameter logic [ADC_CH_W-1:0] V_CH       = 3'd0,
  parameter logic [ADC_CH_W-1:0] I_CH       = 3'd1,
  parameter int                  CUR_OFFSET = 32768
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  input  logic                overrun_clr,
  output logic                adc_sclk,
  output logic                adc_cs_n,
  output logic                adc_mosi,
  input  logic                adc_miso,
  output logic [ADC_BITS-1:0] voltage,
  output logic [ADC_BITS-1:0] current,
  output logic                sample_valid,
  output logic                busy,
  output logic                overrun
);
  localparam int TW = $clog2(CLK_DIV);
  localparam int GW = $clog2(2 * SCLK_HALF + 1);
  localparam logic [ADC_BITS-1:0] OFS = CUR_OFFSET[ADC_BITS-1:0];
  seq_t st, st_n;
  logic [TW-1:0] cnt;
  logic [GW-1:0] gcnt;
  logic tick, start, done, frm, gap_end, fin;
  logic [ADC_BITS-1:0] data, raw_v, cur, cmd;
  assign tick = enable && cnt == TW'(CLK_DIV - 1);
  assign gap_end = gcnt == GW'(2 * SCLK_HALF - 1);
  assign start = (st == S_IDLE && tick) || (st == S_GAP && gap_end);
  assign busy = st == S_FRAME || st == S_GAP;
  assign cmd = adc_cmd(st == S_GAP ? I_CH : V_CH);
  assign fin = st == S_FRAME && done && frm;
  // modulo-2^16 subtraction equals the 17-bit signed difference truncated to 16 bits
  assign cur = data - OFS;
  bms_spi_frame #(.SCLK_HALF(SCLK_HALF)) u_spi (
    .clk(clk), .rst_n(rst_n), .start(start), .cmd(cmd), .done(done), .data(data),
    .sclk(adc_sclk), .cs_n(adc_cs_n), .mosi(adc_mosi), .miso(adc_miso)
  );
  always_ff @(posedge clk) begin
    if (!rst_n) st <= S_IDLE;
    else st <= st_n;
  end
  always_comb begin
    st_n = st;
    case (st)
      S_IDLE:  if (tick) st_n = S_FRAME;
      S_FRAME: if (done) st_n = frm ? S_UPDATE : S_GAP;
      S_GAP:   if (gap_end) st_n = S_FRAME;
      default: st_n = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
      gcnt <= '0;
      frm <= 1'b0;
      raw_v <= '0;
      overrun <= 1'b0;
    end else begin
      cnt <= (!enable || tick) ? '0 : cnt + 1'b1;
      gcnt <= st == S_GAP ? gcnt + 1'b1 : '0;
      if (start) frm <= st == S_GAP;
      if (st == S_FRAME && done && !frm) raw_v <= data;
      overrun <= (tick && busy) || (overrun && !overrun_clr);
    end
  end
`ifdef ADC_AVG_EN
  logic [1:0] ph;
  logic [17:0] acc_v, sum_v;
  logic signed [17:0] acc_i, sum_i;
  assign sum_v = acc_v + {2'b00, raw_v};
  assign sum_i = acc_i + $signed({{2{cur[ADC_BITS-1]}}, cur});
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ph <= '0;
      acc_v <= '0;
      acc_i <= '0;
      voltage <= '0;
      current <= '0;
      sample_valid <= 1'b0;
    end else begin
      sample_valid <= fin && ph == 2'd3;
      if (fin) begin
        ph <= ph + 1'b1;
        acc_v <= ph == 2'd3 ? '0 : sum_v;
        acc_i <= ph == 2'd3 ? '0 : sum_i;
      end
      if (fin && ph == 2'd3) begin
        voltage <= 16'(sum_v >> 2);
        current <= 16'(sum_i >>> 2);
      end
    end
  end
`else
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      voltage <= '0;
      current <= '0;
      sample_valid <= 1'b0;
    end else begin
      sample_valid <= fin;
      if (fin) begin
        voltage <= raw_v;
        current <= cur;
      end
    end
  end
`endif
endmodule

// File: tb/tb_bms_adc_sampler.sv
// tb_bms_adc_sampler: directed bench with a cycle-level behavioural model and an ADC responder
`timescale 1ns/1ps
module tb_bms_adc_sampler;
  localparam int CLK_DIV = 1000, SH = 25, LAT = 70 * SH + 1;
  logic clk = 0, rst_n = 0, enable = 0, overrun_clr = 0, adc_miso = 0;
  logic adc_sclk, adc_cs_n, adc_mosi, sample_valid, busy, overrun;
  logic [15:0] voltage, current;
  int checks = 0, failures = 0, cyc = 0;
  bms_adc_sampler #(.CLK_DIV(CLK_DIV), .SCLK_HALF(SH)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .overrun_clr(overrun_clr),
    .adc_sclk(adc_sclk), .adc_cs_n(adc_cs_n), .adc_mosi(adc_mosi), .adc_miso(adc_miso),
    .voltage(voltage), .current(current), .sample_valid(sample_valid), .busy(busy), .overrun(overrun)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=%0h required=%0h", name, cyc, act, exp);
    end
  endtask
  logic [15:0] vcode = 0, icode = 0, fcode = 0, rx = 0;
  logic par = 0, is_i = 0, abort = 1;
  int bitn = 0, falls = 0, nframes = 0, rise_cyc = 0;
  always @(negedge adc_cs_n) begin
    if (par && !abort) chk("cs_gap", cyc - rise_cyc, 2 * SH);
    abort = 0;
    is_i = par;
    fcode = par ? icode : vcode;
    par = ~par;
    bitn = 0;
    falls = 0;
    rx = 0;
    nframes++;
  end
  always @(negedge adc_sclk) if (!adc_cs_n) begin
    falls++;
    if (bitn < 16) begin
      adc_miso = fcode[15 - bitn];
      bitn++;
    end
  end
  always @(posedge adc_sclk) if (!adc_cs_n) rx = {rx[14:0], adc_mosi};
  always @(posedge adc_cs_n) begin
    rise_cyc = cyc;
    if (!abort) begin
      chk("sclk_falls", falls, 16);
      chk("mosi_cmd", rx, is_i ? 16'h0800 : 16'h0000);
    end
  end
  logic m_act = 0, m_ov = 0, m_vld = 0;
  logic [15:0] m_v = 0, m_i = 0, lv = 0, li = 0;
  int m_ts = 0, m_cnt = 0, vcyc = -1, nvalid = 0, av = 0, ai = 0, ph = 0;
  always @(negedge clk) begin
    int rel, cur;
    logic tick, bz, csl;
    rel = cyc - m_ts;
    bz = m_act && rel >= 1 && rel <= LAT - 1;
    csl = m_act && ((rel >= 1 && rel <= 34 * SH) || (rel >= 36 * SH + 1 && rel <= 70 * SH));
    if (sample_valid === 1'b1) begin
      vcyc = cyc;
      nvalid++;
    end
    if (cyc >= 1) begin
      chk("busy", busy, bz);
      chk("valid", sample_valid, m_vld);
      chk("voltage", voltage, m_v);
      chk("current", current, m_i);
      chk("overrun", overrun, m_ov);
      chk("cs_n", adc_cs_n, !csl);
      if (!m_act) begin
        chk("sclk_idle", adc_sclk, 1);
        chk("mosi_idle", adc_mosi, 0);
      end
    end
    if (!rst_n) begin
      m_act = 0; m_ov = 0; m_vld = 0; m_v = 0; m_i = 0; m_cnt = 0;
      av = 0; ai = 0; ph = 0; abort = 1; par = 0;
    end else begin
      tick = enable && m_cnt == CLK_DIV - 1;
      m_ov = (tick && bz) ? 1'b1 : overrun_clr ? 1'b0 : m_ov;
      if (tick && !m_act) begin
        m_act = 1; m_ts = cyc; lv = vcode; li = icode;
      end else if (m_act && rel == LAT) m_act = 0;
      m_vld = 0;
      if (m_act && cyc + 1 - m_ts == LAT) begin
        cur = int'(li) - 32768;
`ifdef ADC_AVG_EN
        av += int'(lv); ai += cur; ph++;
        if (ph == 4) begin
          m_v = 16'(av / 4); m_i = 16'(ai >>> 2); m_vld = 1; av = 0; ai = 0; ph = 0;
        end
`else
        m_v = lv; m_i = 16'(cur); m_vld = 1;
`endif
      end
      m_cnt = (!enable || tick) ? 0 : m_cnt + 1;
    end
  end
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask
  task automatic run_seq(input logic [15:0] v, input logic [15:0] i, output int e);
    vcode = v; icode = i;
    step(1); enable = 1; e = cyc;
    step(1000); enable = 0;
    step(LAT + 9);
  endtask
  logic [15:0] tv[4], ti[4], ec[4];
  initial begin
    int e, n0, f0;
    tv = '{16'hA5C3, 16'h1234, 16'hFFFF, 16'h0000};
    ti = '{16'h8064, 16'h7F9C, 16'h0000, 16'hFFFF};
    ec = '{16'h0064, 16'hFF9C, 16'h8000, 16'h7FFF};
    step(3); rst_n = 1; step(1);
    chk("rst_voltage", voltage, 0);
    chk("rst_current", current, 0);
    chk("rst_valid", sample_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_cs_n", adc_cs_n, 1);
    chk("rst_sclk", adc_sclk, 1);
    chk("rst_mosi", adc_mosi, 0);
`ifdef ADC_AVG_EN
    n0 = nvalid;
    for (int k = 0; k < 4; k++) run_seq(16'h1000 + 16'(4 * k), k == 3 ? 16'd32772 : 16'd32868, e);
    chk("avg_valid_count", nvalid - n0, 1);
    chk("avg_latency", vcyc, e + 2750);
    chk("avg_voltage", voltage, 16'h1006);
    chk("avg_current", current, 16'd76);
`else
    for (int k = 0; k < 4; k++) begin
      run_seq(tv[k], ti[k], e);
      chk("latency", vcyc, e + 2750);
      chk("voltage_lit", voltage, tv[k]);
      chk("current_lit", current, ec[k]);
    end
`endif
    vcode = 16'hA5C3; icode = 16'h8064;
    f0 = nframes;
    step(1); enable = 1; e = cyc;
    step(1999); chk("ovr_before", overrun, 0);
    step(1); chk("ovr_set", overrun, 1); overrun_clr = 1;
    step(1); overrun_clr = 0; chk("ovr_clr", overrun, 0);
    step(1998); overrun_clr = 1;
    step(1); overrun_clr = 0; enable = 0; chk("ovr_set_wins", overrun, 1);
    step(800); chk("ovr_frames", nframes - f0, 4);
    overrun_clr = 1;
    step(1); overrun_clr = 0; chk("ovr_cleared", overrun, 0);
    step(1); enable = 1;
    step(1000); enable = 0;
    step(300); chk("pre_rst_cs_low", adc_cs_n, 0);
    rst_n = 0;
    step(1); rst_n = 1;
    chk("abort_cs_n", adc_cs_n, 1);
    chk("abort_sclk", adc_sclk, 1);
    chk("abort_voltage", voltage, 0);
    chk("abort_current", current, 0);
    chk("abort_busy", busy, 0);
    n0 = nvalid;
    step(2000); chk("abort_no_valid", nvalid - n0, 0);
    run_seq(tv[0], ti[0], e);
`ifndef ADC_AVG_EN
    chk("resume_latency", vcyc, e + 2750);
    chk("resume_voltage", voltage, 16'hA5C3);
    chk("resume_current", current, 16'h0064);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
